uart_rx_byte: RTL and testbench

- UART receiver for the tile's serial link: 8N1 (or 8E1 with the optional feature), LSB first, oversampled.
- Delivers received bytes on a one-entry valid/ready holding register for the downstream operand-load logic (A/B nibble capture).
- Mirrors the existing transmit path, so the host can both send operands and read results over one UART pair.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_byte.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive (and transmit) paths.
// Receiver FSM encoding, data width and the oversample tick divider
// calculation live here so both directions agree on them.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per oversample tick; never below 1 so a fast baud still ticks.
    function automatic int calc_tick_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-clock tick every TICK_DIV clocks.
// A synchronous restart realigns the phase to a newly seen start edge.
module uart_baud_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider, cleared on restart or on wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver, 8N1, LSB first, oversampled, with a one-entry
// valid/ready holding register on the output side.
// Optional build macro UART_RX_PARITY_EN: 8E1 framing with a PARITY
// state and an active parity_err pulse.
//
// Handshake: rx_data is held stable while rx_valid=1; a transfer happens
// on any clock where rx_valid & rx_ready; rx_valid drops the next cycle
// unless a new byte commits in that same cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic [2:0] state_dbg
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_HALF   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 sync1, rxs;
    rx_state_t            state, state_next;
    logic                 tick, restart;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 mid_start, bit_end;
    logic                 commit, frame_hit;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q;
    logic                 par_hit;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxs   <= sync1;
        end
    end

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    assign mid_start = tick && (tcnt == T_HALF);
    assign bit_end   = tick && (tcnt == T_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rxs) state_next = START;
            START:     if (mid_start) state_next = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (bit_end && (bidx == BIT_LAST)) state_next = PARITY;
            PARITY:    if (bit_end) state_next = STOP;
`else
            DATA:      if (bit_end && (bidx == BIT_LAST)) state_next = STOP;
`endif
            STOP:      if (bit_end) state_next = rxs ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // FSM outputs: tick restart, busy flag and end-of-frame strobes.
    always_comb begin
        restart   = (state == IDLE) && !rxs;
        rx_busy   = (state == DATA) || (state == PARITY) || (state == STOP);
        commit    = 1'b0;
        frame_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_hit   = 1'b0;
`endif
        if ((state == STOP) && bit_end) begin
            if (!rxs) begin
                frame_hit = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_err_q) begin
                par_hit = 1'b1;
`endif
            end else begin
                commit = 1'b1;
            end
        end
    end

    // Bit timing counter, bit index and shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                START: begin
                    if (mid_start) begin
                        tcnt <= '0;
                        bidx <= '0;
                    end else if (tick) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tcnt  <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        bidx  <= bidx + 1'b1;
                    end else if (tick) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tcnt      <= '0;
                        par_err_q <= rxs ^ (^shreg);
                    end else if (tick) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end)   tcnt <= '0;
                    else if (tick) tcnt <= tcnt + 1'b1;
                end
                default: tcnt <= '0;
            endcase
        end
    end

    // Holding register, overrun detection and registered error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_hit;
            overrun   <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch pulse, suppressed when the stop bit is also bad.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_err <= 1'b0;
        else          parity_err <= par_hit;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clocks per bit.
// Stimulus pushes expected bytes into exp_q; the monitor pops on every
// rx_valid & rx_ready transfer. Event counters feed directed checks.
module tb_uart_rx_byte;
    import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun, parity_err;
    logic [2:0] state_dbg;

    uart_rx_byte #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD        (100_000),
        .OVERSAMPLE  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_fail = 0;
    int valid_cnt = 0, busy_cnt = 0, frame_cnt = 0, ovr_cnt = 0, par_cnt = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_xfer = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        if (rx_valid)   valid_cnt++;
        if (rx_busy)    busy_cnt++;
        if (frame_err)  frame_cnt++;
        if (overrun)    ovr_cnt++;
        if (parity_err) par_cnt++;
        if (prev_valid && !prev_xfer && rx_valid) begin
            n_vec++;
            if (rx_data !== prev_data) begin
                n_fail++;
                $display("FAIL data_stable: got %0h expected %0h", rx_data, prev_data);
            end
        end
        if (rx_valid && rx_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected none", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    n_fail++;
                    $display("FAIL rx_byte: got %0h expected %0h", rx_data, e);
                end
            end
        end
        prev_valid = rx_valid;
        prev_xfer  = rx_valid && rx_ready;
        prev_data  = rx_data;
    end

    // Driver tasks: all input changes land 1 time unit after a rising edge.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [10:0] bits, input int nbits);
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = bits[i];
            wait_clk(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
`ifdef UART_RX_PARITY_EN
        send_raw({stop_b, ^b, b, 1'b0}, 11);
`else
        send_raw({1'b0, stop_b, b, 1'b0}, 10);
`endif
    endtask

    // Bounded run time.
    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int s_valid, s_busy, s_frame, s_ovr, s_par;

        // Reset values.
        wait_clk(3);
        check("rst_data",   32'(rx_data),    32'h0);
        check("rst_valid",  32'(rx_valid),   32'h0);
        check("rst_busy",   32'(rx_busy),    32'h0);
        check("rst_frame",  32'(frame_err),  32'h0);
        check("rst_ovr",    32'(overrun),    32'h0);
        check("rst_par",    32'(parity_err), 32'h0);
        check("rst_state",  32'(state_dbg),  32'(IDLE));
        reset_n = 1'b1;
        wait_clk(5);

        // Single byte, consumer always ready.
        s_valid = valid_cnt; s_frame = frame_cnt; s_ovr = ovr_cnt; s_par = par_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_clk(20);
        check("a5_latency",  32'(rise_cyc - start_cyc), 32'(LAT));
        check("a5_pulse",    32'(valid_cnt - s_valid),  32'd1);
        check("a5_frame",    32'(frame_cnt - s_frame),  32'd0);
        check("a5_ovr",      32'(ovr_cnt - s_ovr),      32'd0);
        check("a5_par",      32'(par_cnt - s_par),      32'd0);

        // Back-to-back frames with consumer stalled: second byte overruns.
        rx_ready = 1'b0;
        s_frame = frame_cnt; s_ovr = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_clk(20);
        check("ovr_valid", 32'(rx_valid),           32'h1);
        check("ovr_data",  32'(rx_data),            32'h3C);
        check("ovr_pulse", 32'(ovr_cnt - s_ovr),    32'd1);
        check("ovr_frame", 32'(frame_cnt - s_frame), 32'd0);
        rx_ready = 1'b1;
        wait_clk(2);
        check("ovr_drain",  32'(rx_valid),     32'h0);
        check("ovr_queue",  32'(exp_q.size()), 32'd0);

        // Short low glitch must be rejected.
        s_valid = valid_cnt; s_busy = busy_cnt;
        uart_rxd = 1'b0;
        wait_clk(4);
        uart_rxd = 1'b1;
        wait_clk(40);
        check("glitch_busy",  32'(busy_cnt - s_busy),   32'd0);
        check("glitch_valid", 32'(valid_cnt - s_valid), 32'd0);
        check("glitch_state", 32'(state_dbg),           32'(IDLE));

        // Stop bit low, line held low 40 clocks in total.
        s_valid = valid_cnt; s_frame = frame_cnt;
        send_frame(8'h55, 1'b0);
        wait_clk(24);
        check("ferr_state", 32'(state_dbg), 32'(WAIT_HIGH));
        check("ferr_busy",  32'(rx_busy),   32'h0);
        uart_rxd = 1'b1;
        wait_clk(20);
        check("ferr_pulse", 32'(frame_cnt - s_frame), 32'd1);
        check("ferr_valid", 32'(valid_cnt - s_valid), 32'd0);
        check("ferr_idle",  32'(state_dbg),           32'(IDLE));
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_clk(20);
        check("ferr_recover", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a 0xFF frame, then a clean 0x12.
        s_valid = valid_cnt; s_frame = frame_cnt;
        uart_rxd = 1'b0;
        wait_clk(16);
        uart_rxd = 1'b1;
        wait_clk(40);
        check("mid_busy", 32'(rx_busy), 32'h1);
        reset_n = 1'b0;
        wait_clk(2);
        check("mrst_data",  32'(rx_data),   32'h0);
        check("mrst_valid", 32'(rx_valid),  32'h0);
        check("mrst_busy",  32'(rx_busy),   32'h0);
        check("mrst_state", 32'(state_dbg), 32'(IDLE));
        reset_n = 1'b1;
        wait_clk(128);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_clk(20);
        check("mrst_count", 32'(valid_cnt - s_valid), 32'd1);
        check("mrst_frame", 32'(frame_cnt - s_frame), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones so the parity bit is 1.
        s_valid = valid_cnt; s_par = par_cnt;
        exp_q.push_back(8'h07);
        send_raw({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        wait_clk(20);
        check("par_ok_valid", 32'(valid_cnt - s_valid), 32'd1);
        check("par_ok_err",   32'(par_cnt - s_par),     32'd0);
        s_valid = valid_cnt; s_par = par_cnt; s_frame = frame_cnt;
        send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        wait_clk(20);
        check("par_bad_err",   32'(par_cnt - s_par),     32'd1);
        check("par_bad_valid", 32'(valid_cnt - s_valid), 32'd0);
        check("par_bad_frame", 32'(frame_cnt - s_frame), 32'd0);
`endif

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
